// File: rtl/mmc3_chr_window.sv
// MMC3-class mapper core with an aligned CHR-RAM overlay window; address outputs are combinational,
// irq is registered. No backpressure: CPU writes and PPU fetches are accepted every clk.
module mmc3_chr_window #(
  parameter int PRG_AW   = 19,
  parameter int CHR_AW   = 18,
  parameter int RAM_LO   = 8,
  parameter int RAM_CNT  = 4,
  parameter int A12_FILT = 3,
  localparam int PB      = PRG_AW - 13,
  localparam int CB      = CHR_AW - 10,
  localparam int RAM_AW  = (RAM_CNT > 1) ? $clog2(RAM_CNT) : 1,
  localparam int FW      = (A12_FILT > 0) ? $clog2(A12_FILT + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_wr_stb,
  input  logic [13:0]       ppu_addr,
  input  logic              mir_h_def,
  output logic              prg_ce,
  output logic [PB-1:0]     prg_addr,
  output logic [CB-1:0]     chr_addr,
  output logic              chr_ram_ce,
  output logic [RAM_AW-1:0] chr_ram_addr,
  output logic              ciram_a10,
  output logic              srm_ce,
  output logic              srm_we_en,
  output logic              irq
);

  localparam logic [PB-1:0] PRG_LAST  = '1;
  localparam logic [PB-1:0] PRG_SLAST = PRG_LAST - PB'(1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(A12_FILT);

  logic [7:0]    r_q [8];
  logic [7:0]    r_d [8];
  logic [2:0]    sel_q, sel_d;
  logic          prg_mode_q, prg_mode_d;
  logic          chr_inv_q, chr_inv_d;
  logic          mir_q, mir_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_wp_q, ram_wp_d;
  logic [7:0]    latch_q, latch_d;
  logic [7:0]    counter_q, counter_d;
  logic          reload_q, reload_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic [FW-1:0] low_cnt_q, low_cnt_d;
  logic          a12_prev_q, a12_prev_d;

  logic          wr;
  logic [2:0]    wsel;
  logic          a12;
  logic          qual_clk;
  logic [7:0]    cnt_next;

  assign wr       = cpu_wr_stb & cpu_addr[15];
  assign wsel     = {cpu_addr[14:13], cpu_addr[0]};
  assign a12      = ppu_addr[12];
  // A rise only counts after A12 has been held low for the full filter time.
  assign qual_clk = a12 & ~a12_prev_q & (low_cnt_q == FILT_MAX);
  assign cnt_next = ((counter_q == 8'd0) || reload_q) ? latch_q : (counter_q - 8'd1);

  always_comb begin
    for (int i = 0; i < 8; i++) r_d[i] = r_q[i];
    sel_d      = sel_q;
    prg_mode_d = prg_mode_q;
    chr_inv_d  = chr_inv_q;
    mir_d      = mir_q;
    ram_en_d   = ram_en_q;
    ram_wp_d   = ram_wp_q;
    latch_d    = latch_q;
    counter_d  = counter_q;
    reload_d   = reload_q;
    irq_en_d   = irq_en_q;
    irq_d      = irq_q;
    a12_prev_d = a12;

    if (a12) begin
      low_cnt_d = '0;
    end else if (low_cnt_q == FILT_MAX) begin
      low_cnt_d = low_cnt_q;
    end else begin
      low_cnt_d = low_cnt_q + FW'(1);
    end

    if (qual_clk) begin
      counter_d = cnt_next;
      reload_d  = 1'b0;
      if ((cnt_next == 8'd0) && irq_en_q) irq_d = 1'b1;
    end

    // Register writes come last so they override a same-cycle counter event.
    if (wr) begin
      case (wsel)
        3'b000: begin
          sel_d      = cpu_data[2:0];
          prg_mode_d = cpu_data[6];
          chr_inv_d  = cpu_data[7];
        end
        3'b001: r_d[sel_q] = cpu_data;
        3'b010: mir_d = cpu_data[0];
        3'b011: begin
          ram_en_d = cpu_data[7];
          ram_wp_d = cpu_data[6];
        end
        3'b100: latch_d = cpu_data;
        3'b101: begin
          reload_d  = 1'b1;
          counter_d = 8'd0;
          irq_d     = irq_q;
        end
        3'b110: begin
          irq_en_d = 1'b0;
          irq_d    = 1'b0;
        end
        default: irq_en_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q[0]     <= 8'd0;
      r_q[1]     <= 8'd2;
      r_q[2]     <= 8'd4;
      r_q[3]     <= 8'd5;
      r_q[4]     <= 8'd6;
      r_q[5]     <= 8'd7;
      r_q[6]     <= 8'd0;
      r_q[7]     <= 8'd1;
      sel_q      <= 3'd0;
      prg_mode_q <= 1'b0;
      chr_inv_q  <= 1'b0;
      mir_q      <= mir_h_def;
      ram_en_q   <= 1'b1;
      ram_wp_q   <= 1'b0;
      latch_q    <= 8'd0;
      counter_q  <= 8'd0;
      reload_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      low_cnt_q  <= '0;
      a12_prev_q <= 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) r_q[i] <= r_d[i];
      sel_q      <= sel_d;
      prg_mode_q <= prg_mode_d;
      chr_inv_q  <= chr_inv_d;
      mir_q      <= mir_d;
      ram_en_q   <= ram_en_d;
      ram_wp_q   <= ram_wp_d;
      latch_q    <= latch_d;
      counter_q  <= counter_d;
      reload_q   <= reload_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      low_cnt_q  <= low_cnt_d;
      a12_prev_q <= a12_prev_d;
    end
  end

  logic [15:0] r6_ext, r7_ext;
  assign r6_ext = {8'd0, r_q[6]};
  assign r7_ext = {8'd0, r_q[7]};

  always_comb begin
    prg_addr = PRG_LAST;
    case (cpu_addr[14:13])
      2'd0:    prg_addr = prg_mode_q ? PRG_SLAST : r6_ext[PB-1:0];
      2'd1:    prg_addr = r7_ext[PB-1:0];
      2'd2:    prg_addr = prg_mode_q ? r6_ext[PB-1:0] : PRG_SLAST;
      default: prg_addr = PRG_LAST;
    endcase
  end

  logic [2:0]  slot;
  logic [7:0]  b;
  logic [15:0] b_ext;

  assign slot = ppu_addr[12:10] ^ {chr_inv_q, 2'b00};

  always_comb begin
    b = 8'd0;
    case (slot)
      3'd0:    b = r_q[0] & 8'hFE;
      3'd1:    b = r_q[0] | 8'h01;
      3'd2:    b = r_q[1] & 8'hFE;
      3'd3:    b = r_q[1] | 8'h01;
      3'd4:    b = r_q[2];
      3'd5:    b = r_q[3];
      3'd6:    b = r_q[4];
      default: b = r_q[5];
    endcase
  end

  assign b_ext      = {8'd0, b};
  assign chr_addr   = b_ext[CB-1:0];
  // Compare at full integer width so a window near bank 255 never wraps.
  assign chr_ram_ce = (RAM_CNT != 0) && !ppu_addr[13] &&
                      (int'(b) >= RAM_LO) && (int'(b) < RAM_LO + RAM_CNT);
  assign chr_ram_addr = (chr_ram_ce && (RAM_CNT > 1)) ? b[RAM_AW-1:0] : '0;

  assign prg_ce    = cpu_addr[15];
  assign ciram_a10 = mir_q ? ppu_addr[11] : ppu_addr[10];
  assign srm_ce    = (cpu_addr[15:13] == 3'b011) & ram_en_q;
  assign srm_we_en = ram_en_q & ~ram_wp_q;
  assign irq       = irq_q;

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[12:1], ppu_addr[9:0], b_ext, r6_ext, r7_ext};

endmodule

// File: tb/tb_mmc3_chr_window.sv
// Directed bench for mmc3_chr_window: default-window instance plus a RAM_LO=0/RAM_CNT=2 instance
// sharing the same CPU/PPU stimulus.
module tb_mmc3_chr_window;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr_stb;
  logic [13:0] ppu_addr;
  logic        mir_h_def;

  logic       prg_ce, chr_ram_ce, ciram_a10, srm_ce, srm_we_en, irq;
  logic [5:0] prg_addr;
  logic [7:0] chr_addr;
  logic [1:0] chr_ram_addr;

  logic       prg_ce1, chr_ram_ce1, ciram_a10_1, srm_ce1, srm_we_en1, irq1;
  logic [5:0] prg_addr1;
  logic [7:0] chr_addr1;
  logic [0:0] chr_ram_addr1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmc3_chr_window u_dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr_stb(cpu_wr_stb),
    .ppu_addr(ppu_addr), .mir_h_def(mir_h_def), .prg_ce(prg_ce), .prg_addr(prg_addr),
    .chr_addr(chr_addr), .chr_ram_ce(chr_ram_ce), .chr_ram_addr(chr_ram_addr),
    .ciram_a10(ciram_a10), .srm_ce(srm_ce), .srm_we_en(srm_we_en), .irq(irq)
  );

  mmc3_chr_window #(.RAM_LO(0), .RAM_CNT(2)) u_dut_lo (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr_stb(cpu_wr_stb),
    .ppu_addr(ppu_addr), .mir_h_def(mir_h_def), .prg_ce(prg_ce1), .prg_addr(prg_addr1),
    .chr_addr(chr_addr1), .chr_ram_ce(chr_ram_ce1), .chr_ram_addr(chr_ram_addr1),
    .ciram_a10(ciram_a10_1), .srm_ce(srm_ce1), .srm_we_en(srm_we_en1), .irq(irq1)
  );

  task do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_wr_stb = 1'b0;
    ppu_addr = 14'h1000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    cpu_data = d;
    cpu_wr_stb = 1'b1;
    @(negedge clk);
    cpu_wr_stb = 1'b0;
  endtask

  task a12_rise(input int lows);
    @(negedge clk);
    ppu_addr = 14'h0000;
    repeat (lows) @(negedge clk);
    ppu_addr = 14'h1000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task a12_rise_wr(input int lows, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ppu_addr = 14'h0000;
    repeat (lows) @(negedge clk);
    ppu_addr = 14'h1000;
    cpu_addr = a;
    cpu_data = d;
    cpu_wr_stb = 1'b1;
    @(negedge clk);
    cpu_wr_stb = 1'b0;
    @(negedge clk);
  endtask

  task test_reset();
    logic [5:0] exp_prg [4];
    exp_prg = '{6'h00, 6'h01, 6'h3E, 6'h3F};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 16'h8000 | (16'(i) << 13);
      #1;
      checks++;
      if (prg_addr !== exp_prg[i] || prg_ce !== 1'b1) begin
        failures++;
        $display("FAIL reset_prg[%0d] got bank=%h ce=%b want bank=%h ce=1", i, prg_addr, prg_ce, exp_prg[i]);
      end
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", irq); end
    ppu_addr = 14'h0800;
    #1;
    checks++;
    if (ciram_a10 !== 1'b1) begin failures++; $display("FAIL reset_mir got %b want 1", ciram_a10); end
    cpu_addr = 16'h6000;
    #1;
    checks++;
    if (srm_ce !== 1'b1 || srm_we_en !== 1'b1 || prg_ce !== 1'b0) begin
      failures++;
      $display("FAIL reset_wram got ce=%b we=%b prg_ce=%b want 1 1 0", srm_ce, srm_we_en, prg_ce);
    end
    ppu_addr = 14'h1C00;
    #1;
    checks++;
    if (chr_addr !== 8'h07 || chr_ram_ce !== 1'b0) begin
      failures++;
      $display("FAIL reset_chr_r5 got bank=%h ram=%b want 07 0", chr_addr, chr_ram_ce);
    end
    ppu_addr = 14'h0400;
    #1;
    checks++;
    if (chr_addr !== 8'h01) begin failures++; $display("FAIL reset_chr_r0 got %h want 01", chr_addr); end
  endtask

  task test_prg_mode();
    logic [5:0] exp_prg [4];
    exp_prg = '{6'h3E, 6'h01, 6'h00, 6'h3F};
    cpu_wr(16'h8000, 8'h40);
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 16'h8000 | (16'(i) << 13);
      #1;
      checks++;
      if (prg_addr !== exp_prg[i]) begin
        failures++;
        $display("FAIL prg_mode1[%0d] got %h want %h", i, prg_addr, exp_prg[i]);
      end
    end
  endtask

  task test_chr_window();
    do_reset();
    cpu_wr(16'h8000, 8'h02);
    cpu_wr(16'h8001, 8'h09);
    ppu_addr = 14'h1000;
    #1;
    checks++;
    if (chr_ram_ce !== 1'b1 || chr_ram_addr !== 2'd1) begin
      failures++;
      $display("FAIL win_in got ce=%b idx=%0d want 1 1", chr_ram_ce, chr_ram_addr);
    end
    ppu_addr = 14'h3000;
    #1;
    checks++;
    if (chr_ram_ce !== 1'b0) begin failures++; $display("FAIL win_nametable got %b want 0", chr_ram_ce); end
    ppu_addr = 14'h1000;
    cpu_wr(16'h8001, 8'h0C);
    #1;
    checks++;
    if (chr_ram_ce !== 1'b0 || chr_addr !== 8'h0C || chr_ram_addr !== 2'd0) begin
      failures++;
      $display("FAIL win_above got ce=%b bank=%h idx=%0d want 0 0c 0", chr_ram_ce, chr_addr, chr_ram_addr);
    end
    cpu_wr(16'h8001, 8'h01);
    #1;
    checks++;
    if (chr_ram_ce1 !== 1'b1 || chr_ram_addr1 !== 1'b1 || chr_ram_ce !== 1'b0 || chr_addr !== 8'h01) begin
      failures++;
      $display("FAIL win_lo_bank1 got lo_ce=%b lo_idx=%b def_ce=%b def_bank=%h want 1 1 0 01",
               chr_ram_ce1, chr_ram_addr1, chr_ram_ce, chr_addr);
    end
    cpu_wr(16'h8001, 8'h02);
    #1;
    checks++;
    if (chr_ram_ce1 !== 1'b0 || chr_addr1 !== 8'h02) begin
      failures++;
      $display("FAIL win_lo_bank2 got ce=%b bank=%h want 0 02", chr_ram_ce1, chr_addr1);
    end
  endtask

  task test_chr_inv();
    do_reset();
    cpu_wr(16'h8000, 8'h80);
    cpu_wr(16'h8001, 8'h04);
    ppu_addr = 14'h1400;
    #1;
    checks++;
    if (chr_addr !== 8'h05) begin failures++; $display("FAIL inv_1400 got %h want 05", chr_addr); end
    ppu_addr = 14'h0000;
    #1;
    checks++;
    if (chr_addr !== 8'h04) begin failures++; $display("FAIL inv_0000 got %h want 04", chr_addr); end
    ppu_addr = 14'h1000;
    #1;
    checks++;
    if (chr_addr !== 8'h04) begin failures++; $display("FAIL inv_1000 got %h want 04", chr_addr); end
  endtask

  task test_mirror_wram();
    do_reset();
    ppu_addr = 14'h0400;
    #1;
    checks++;
    if (ciram_a10 !== 1'b0) begin failures++; $display("FAIL mir_h got %b want 0", ciram_a10); end
    cpu_wr(16'hA000, 8'h00);
    #1;
    checks++;
    if (ciram_a10 !== 1'b1) begin failures++; $display("FAIL mir_v got %b want 1", ciram_a10); end
    cpu_wr(16'hA001, 8'h00);
    cpu_addr = 16'h6000;
    #1;
    checks++;
    if (srm_ce !== 1'b0 || srm_we_en !== 1'b0) begin
      failures++;
      $display("FAIL wram_off got ce=%b we=%b want 0 0", srm_ce, srm_we_en);
    end
    cpu_wr(16'hA001, 8'hC0);
    cpu_addr = 16'h6000;
    #1;
    checks++;
    if (srm_ce !== 1'b1 || srm_we_en !== 1'b0) begin
      failures++;
      $display("FAIL wram_wp got ce=%b we=%b want 1 0", srm_ce, srm_we_en);
    end
  endtask

  task test_irq();
    do_reset();
    cpu_wr(16'hC000, 8'd3);
    cpu_wr(16'hC001, 8'h00);
    cpu_wr(16'hE001, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      a12_rise(3);
      checks++;
      if (irq !== (k == 4)) begin
        failures++;
        $display("FAIL irq_rise%0d got %b want %b", k, irq, (k == 4));
      end
    end
    cpu_wr(16'hE000, 8'h00);
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack got %b want 0", irq); end
    cpu_wr(16'hC000, 8'd2);
    cpu_wr(16'hC001, 8'h00);
    cpu_wr(16'hE001, 8'h00);
    a12_rise(3);
    a12_rise(1);
    a12_rise(3);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_short_rise got %b want 0", irq); end
    a12_rise(3);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_short got %b want 1", irq); end
  endtask

  task test_back_to_back();
    do_reset();
    cpu_wr(16'hC000, 8'd0);
    cpu_wr(16'hC001, 8'h00);
    cpu_wr(16'hE001, 8'h00);
    a12_rise_wr(3, 16'hE000, 8'h00);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL b2b_ack_vs_set got %b want 0", irq); end
    cpu_wr(16'hE001, 8'h00);
    a12_rise_wr(3, 16'hC001, 8'h00);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL b2b_reload_vs_clock got %b want 0", irq); end
    cpu_wr(16'h8000, 8'h40);
    cpu_wr(16'hA000, 8'h00);
    a12_rise(3);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL b2b_fire got %b want 1", irq); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cpu_addr = 16'h8000;
    ppu_addr = 14'h0800;
    #1;
    checks++;
    if (irq !== 1'b0 || prg_addr !== 6'h00 || ciram_a10 !== 1'b1) begin
      failures++;
      $display("FAIL midframe_rst got irq=%b prg=%h a10=%b want 0 00 1", irq, prg_addr, ciram_a10);
    end
    cpu_addr = 16'hC000;
    #1;
    checks++;
    if (prg_addr !== 6'h3E) begin failures++; $display("FAIL midframe_rst_mode got %h want 3e", prg_addr); end
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
    cpu_wr_stb = 1'b0;
    ppu_addr = 14'h1000;
    mir_h_def = 1'b1;
    test_reset();
    test_prg_mode();
    test_chr_window();
    test_chr_inv();
    test_mirror_wram();
    test_irq();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmc3_chr_window.md
Name: mmc3_chr_window

Overview:
- Self-contained MMC3-class mapper core with a parametrised CHR-RAM overlay window. Generalises the fixed "banks 8–11 → 4 KB CHR-RAM" scheme to any aligned window, so one core covers the 074/191/192/194 family.
- Contains the bank registers, PRG/CHR address generation, mirroring, WRAM protect and the A12 scanline IRQ counter.
- Sits between the CPU/PPU bus adapter and the memory controller inside a mapper top.

Parameters:
- PRG_AW, 19: PRG address width; 8 KB banks, so PRG_AW-13 bank bits.
- CHR_AW, 18: CHR ROM address width; 1 KB banks, so CHR_AW-10 bank bits.
- RAM_LO, 8: first 1 KB CHR bank number redirected to CHR-RAM. Must be a multiple of RAM_CNT.
- RAM_CNT, 4: number of redirected 1 KB banks; power of 2, 1..8. 0 disables the window.
- A12_FILT, 3: clk cycles PPU A12 must stay low before a rise is counted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU write data
- cpu_wr_stb  in  1  one-clk pulse per CPU write cycle, with addr/data valid
- ppu_addr  in  14  PPU address
- mir_h_def  in  1  mirroring value loaded at reset (1 = horizontal)
- prg_ce  out  1  cpu_addr[15]
- prg_addr  out  PRG_AW-13  PRG bank, bits [PRG_AW-1:13]
- chr_addr  out  CHR_AW-10  CHR ROM bank, bits [CHR_AW-1:10]
- chr_ram_ce  out  1  current PPU fetch is inside the RAM window
- chr_ram_addr  out  log2(RAM_CNT)  RAM bank index, bits above ppu_addr[9:0]
- ciram_a10  out  1  nametable A10
- srm_ce  out  1  $6000–$7FFF and WRAM enabled
- srm_we_en  out  1  WRAM writable
- irq  out  1  level IRQ request, active high

Behaviour:
- All outputs except irq are combinational from the registers and current addresses. irq is registered.
- Register writes (on clk with cpu_wr_stb & cpu_addr[15]), decoded by {addr[14:13], addr[0]}:
  - 000 $8000: sel[2:0]=d[2:0], prg_mode=d[6], chr_inv=d[7]
  - 001 $8001: R[sel]=d
  - 010 $A000: mir=d[0]
  - 011 $A001: ram_en=d[7], ram_wp=d[6]
  - 100 $C000: latch=d
  - 101 $C001: reload=1, counter=0
  - 110 $E000: irq_en=0, irq=0
  - 111 $E001: irq_en=1
- Reset values: R0..R7 = 0,2,4,5,6,7,0,1; sel=0; prg_mode=0; chr_inv=0; mir=mir_h_def; ram_en=1; ram_wp=0; latch=0; counter=0; reload=0; irq_en=0; irq=0; A12 filter count=0.
- PRG mapping by cpu_addr[14:13]. "-2" and "-1" mean all-ones with LSB 0 and all-ones, at PRG_AW-13 bits. Bank values are truncated to width.
  - prg_mode=0: R6, R7, -2, -1.
  - prg_mode=1: -2, R7, R6, -1.
- CHR mapping: slot = ppu_addr[12:10] XOR {chr_inv,0,0}.
  - Slots 0/1: R0&~1, R0|1.
  - Slots 2/3: R1&~1, R1|1.
  - Slots 4..7: R2..R5.
  - Result is the raw bank b (8 bits).
- Window check: chr_ram_ce = (RAM_CNT≠0) & ppu_addr[13]==0 & b≥RAM_LO & b<RAM_LO+RAM_CNT. Full 8-bit compare, so no wrap.
  - If chr_ram_ce: chr_ram_addr = b[log2(RAM_CNT)-1:0], and chr_addr = b truncated (don't-care).
  - Else chr_ram_addr=0.
- ciram_a10 = mir ? ppu_addr[11] : ppu_addr[10].
- srm_ce = cpu_addr[15:13]==3'b011 & ram_en. srm_we_en = ram_en & ~ram_wp.
- A12 filter:
  - While ppu_addr[12]=0, the low count increments, saturating at A12_FILT.
  - A rise (low last clk, 1 now) with low count==A12_FILT is a qualified clock.
  - Any high sample clears the low count.
- IRQ counter on each qualified clock:
  - If counter==0 or reload: counter=latch, reload=0.
  - Else counter=counter-1.
  - Then, if the resulting value is 0 and irq_en: irq=1 on the next clk edge.
  - Latch=0 therefore fires on every qualified clock.
- Simultaneous events:
  - A $E000 write in the same clk as an IRQ set: the write wins, irq=0.
  - A $C001 write in the same clk as a qualified clock: the write wins, counter=0 and reload=1, and that clock is not counted.
- irq stays high until a $E000 write or rst.
- rst mid-frame restores all reset values in one clk; irq drops the next edge.

Test Plan:
- Reset then read $8000/$A000/$C000/$E000 with prg_mode=0 and PRG_AW=19 → prg_addr = 0, 1, 0x3E, 0x3F. Write $8000=0x40 → prg_addr = 0x3E, 1, 0, 0x3F.
- Default params: $8000=2, $8001=0x09, then PPU fetch $1000 → chr_ram_ce=1, chr_ram_addr=1. Write $8001=0x0C → chr_ram_ce=0, chr_addr=0x0C. Repeat with RAM_LO=0, RAM_CNT=2: bank 1 → RAM, bank 2 → ROM.
- chr_inv: $8000=0x80, $8001(R0)=0x04, then fetch $1400 → chr_addr=0x05. Fetch $0000 → bank R2.
- IRQ: latch=3, $C001, $E001, then 4 A12 rises each preceded by ≥3 low clks → irq asserts after the 4th (reload 3, 2, 1, 0). $E000 → irq=0. A rise after only 1 low clk → no decrement.
- $E000 and IRQ set in the same clk → irq stays 0. rst while irq=1 → irq=0 and all registers at reset values the next edge.
